// File: rtl/cla_pipe_adder.sv
// Pipelined adder: one SLICE-bit carry-lookahead slice per stage, skewed operands,
// with a single global advance shared by every stage and by both handshakes.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SLICE;
  // Operand registers are only needed between stages; the last stage consumes the final slice.
  localparam int unsigned OP_REGS = (STAGES > 1) ? STAGES - 1 : 1;

  if ((WIDTH % SLICE) != 0) begin : g_width_check
    $error("cla_pipe_adder: WIDTH must be a multiple of SLICE");
  end

  // Flattened lookahead: every carry is a sum of generate terms gated by propagate runs.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             ci);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             t;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int unsigned i = 0; i <= SLICE; i++) begin
      t = ci;
      for (int unsigned j = 0; j < i; j++) t = t & p[j];
      c[i] = t;
      for (int unsigned j = 0; j < i; j++) begin
        t = g[j];
        for (int unsigned m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [OP_REGS];
  logic [WIDTH-1:0] r_b   [OP_REGS];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;

  logic             w_adv;
  logic             w_v_in [STAGES];
  logic [WIDTH-1:0] w_a_in [STAGES];
  logic [WIDTH-1:0] w_b_in [STAGES];
  logic [WIDTH-1:0] w_s_nx [STAGES];
  logic             w_c_nx [STAGES];
  logic             w_ovf_nx;

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

  // Per-stage slice add: stage 0 reads the ports, later stages read their predecessor.
  always_comb begin
    logic [SLICE:0]   res;
    logic             ci;
    logic [WIDTH-1:0] s_in;
    res      = '0;
    ci       = cin;
    s_in     = '0;
    w_ovf_nx = 1'b0;

    w_v_in[0] = in_valid;
    w_a_in[0] = a;
    w_b_in[0] = b;
    res       = cla_slice(a[SLICE-1:0], b[SLICE-1:0], cin);
    w_s_nx[0] = '0;
    w_s_nx[0][SLICE-1:0] = res[SLICE-1:0];
    w_c_nx[0] = res[SLICE];

    for (int unsigned k = 1; k < STAGES; k++) begin
      w_v_in[k] = r_vld[k-1];
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      ci        = r_c[k-1];
      s_in      = r_s[k-1];
      res       = cla_slice(w_a_in[k][k*SLICE +: SLICE], w_b_in[k][k*SLICE +: SLICE], ci);
      w_s_nx[k] = s_in;
      w_s_nx[k][k*SLICE +: SLICE] = res[SLICE-1:0];
      w_c_nx[k] = res[SLICE];
    end

    // Carry into the MSB is a^b^sum at that bit; XOR with carry-out gives signed overflow.
    w_ovf_nx = w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1]
             ^ w_s_nx[STAGES-1][WIDTH-1] ^ w_c_nx[STAGES-1];
  end

  // Pipeline registers: valid bits shift on every advance; data only follows real tokens,
  // so the output keeps its last result while bubbles pass through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      for (int unsigned k = 0; k < OP_REGS; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_v_in[k];
        if (w_v_in[k]) begin
          r_s[k] <= w_s_nx[k];
          r_c[k] <= w_c_nx[k];
        end
      end
      for (int unsigned k = 0; k < STAGES - 1; k++) begin
        if (w_v_in[k]) begin
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
        end
      end
      if (w_v_in[STAGES-1]) r_ovf <= w_ovf_nx;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench: accepted inputs push a model result, the monitor checks each presented output.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_total = 0;
  int n_pass  = 0;
  int acc_cnt = 0;
  int cyc     = 0;
  logic [17:0] exp_q[$];
  logic        vout_log [4096];

  cla_pipe_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
  endtask

  // Reference: 17-bit arithmetic sum; signed overflow when same-sign operands give other sign.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] s;
    logic        v;
    s = {1'b0, x} + {1'b0, y} + {16'd0, c};
    v = (x[15] == y[15]) && (s[15] != x[15]);
    return {s[16], v, s[15:0]};
  endfunction

  // Input-side observer: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin));
      acc_cnt++;
    end
  end

  // Output monitor: compares against the queue head while valid, pops on handshake.
  always @(negedge clk) begin
    logic [17:0] e;
    cyc++;
    vout_log[cyc % 4096] = out_valid;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q[0];
        chk("sum", {16'd0, sum}, {16'd0, e[15:0]});
        chk("cout", {31'd0, cout}, {31'd0, e[17]});
        chk("ovf", {31'd0, ovf}, {31'd0, e[16]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
    int t;
    t = 0;
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    int          start;
    int          base;
    bit          done;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back.
    send(16'h1234, 16'h4321, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'h8000, 16'hFFFF, 1'b0);
    drain();

    // Reset with three tokens in flight: they must never appear.
    send(16'hAAAA, 16'h1111, 1'b1);
    send(16'h0F0F, 16'hF0F0, 1'b1);
    send(16'h1357, 16'h2468, 1'b0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Random back-to-back with out_ready always high.
    for (int i = 0; i < 30; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    drain();

    // Random with random consumer backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Backpressure: six tokens against a stalled consumer.
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
      end
      begin
        int t;
        t = 0;
        do begin
          @(posedge clk);
          #2 t++;
        end while (acc_cnt - base < 4 && t < 50);
        chk("bp_accepts_when_full", acc_cnt - base, 32'd4);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (3) begin
          @(posedge clk);
          #2;
          chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
          chk("bp_full_out_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_accepts_hold", acc_cnt - base, 32'd4);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total_accepts", acc_cnt - base, 32'd6);

    // Bubbles: out_valid must replay the in_valid pattern four cycles later.
    pat = 16'b1011_0010_1100_1101;
    start = cyc;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      in_valid = pat[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("bubble_out_valid", {31'd0, vout_log[(start + 1 + i + 4) % 4096]}, {31'd0, pat[i]});
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
